// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer stage feeding the serial sequence detector.
package serdes_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer_piso_if.sv
// Word-load handshake between the upstream producer and the serializer.
interface bit_serializer_piso_if
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/bit_serializer_piso.sv
// Parallel-in / serial-out stage: one bit per clock, back-to-back words with no gap,
// defined idle level between words because the downstream detector samples every clock.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | no word loaded, dout = IDLE_LEVEL, ready for a new word
//   ST_SHIFT | word in flight, dout = current output bit of shreg
module bit_serializer_piso
    import serdes_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    bit_serializer_piso_if.slave  ld,
    output logic                  dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam int            OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;
    localparam int            NXT_IDX = MSB_FIRST ? WIDTH - 2 : 1;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             accept;

    always_comb begin
        ld.load_ready = rst && ((state == ST_IDLE) || (cnt == LAST));
        accept        = ld.load_valid && ld.load_ready;
    end

    always_comb begin
        shreg_shifted = '0;
        if (MSB_FIRST) shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        else           shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
    end

    // dout always mirrors the output end of shreg while shifting, so the outputs are
    // computed from next-state values and stay purely registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            dout       <= IDLE_LEVEL;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (accept) begin
            state      <= ST_SHIFT;
            shreg      <= ld.load_data;
            cnt        <= '0;
            dout       <= ld.load_data[OUT_IDX];
            dout_valid <= 1'b1;
            busy       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dout       <= IDLE_LEVEL;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
                ST_SHIFT: begin
                    shreg <= shreg_shifted;
                    if (cnt == LAST) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        dout       <= IDLE_LEVEL;
                        dout_valid <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        cnt        <= cnt + CW'(1);
                        dout       <= shreg[NXT_IDX];
                        frame_done <= ((cnt + CW'(1)) == LAST);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bit_serializer_piso.md
Name: bit_serializer_piso

Overview:
- Parallel-in / serial-out stage placed directly upstream of the 1011 Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits one bit per clock on dout, wired straight to the detector's serial din. The detector samples every clock, so dout must hold a defined idle level between words.
- Supports back-to-back words with no gap bit.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
- IDLE_LEVEL, 0: value driven on dout when no word is being shifted.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- load_valid  input  1  upstream presents a word on load_data.
- load_data  input  WIDTH  word to serialize; sampled only on accept.
- load_ready  output  1  stage can accept a word this cycle.
- dout  output  1  serial bit, to detector din.
- dout_valid  output  1  dout carries a data bit, not idle fill.
- busy  output  1  a word is being shifted.
- frame_done  output  1  one-cycle pulse while the last bit of a word is on dout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - dout=IDLE_LEVEL, dout_valid=0, busy=0, frame_done=0.
  - load_ready forced 0 while rst=0.
- Reset asserted mid-word: the word is discarded immediately. No partial frame_done. After release, the stage sits in IDLE with load_ready=1.
- States: IDLE, SHIFT. State encoding is 1 bit.
- load_ready (combinational): rst && (state==IDLE || (state==SHIFT && cnt==WIDTH-1)).
- Accept condition: load_valid && load_ready at a rising edge.
- IDLE:
  - dout=IDLE_LEVEL, dout_valid=0, busy=0.
  - On accept: capture load_data into shreg, cnt<=0, go to SHIFT.
  - The first bit appears on dout in the cycle after the accept edge, so latency is 1 cycle.
- SHIFT:
  - dout is registered and equals shreg[WIDTH-1] when MSB_FIRST=1, or shreg[0] when MSB_FIRST=0. dout_valid=1, busy=1.
  - Each edge: shreg shifts by one toward the output bit (zero fill) and cnt increments.
  - frame_done=1 exactly when cnt==WIDTH-1, i.e. the last bit is being driven.
- End of word (cnt==WIDTH-1):
  - With an accept on that edge: reload shreg, cnt<=0, stay in SHIFT. The new word's first bit follows with no gap.
  - Without an accept: go to IDLE, and dout returns to IDLE_LEVEL on the next cycle.
- load_valid held high while busy and cnt<WIDTH-1: not accepted and load_data ignored. It is accepted at the last-bit edge.
- A word occupies exactly WIDTH dout cycles. Continuous input gives 100% dout_valid duty.
- cnt width: $clog2(WIDTH). cnt never exceeds WIDTH-1; there is no wrap beyond the terminal count.
- No combinational path from load_valid or load_data to dout. dout, dout_valid and frame_done are all registered.

Decomposition:
- Shared package `serdes_pkg`:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the default WIDTH.
- No sub-module. Shift register, counter and 2-state FSM stay in one module.

Test Plan:
- Reset: hold rst=0 for 3 cycles with load_valid=1 -> load_ready=0, dout=0, dout_valid=0, busy=0. Release -> load_ready=1 on the next cycle.
- Single word MSB_FIRST=1, load_data=8'hB4 -> dout = 1,0,1,1,0,1,0,0 on cycles 1..8 after accept. dout_valid=1 on those cycles, frame_done only on cycle 8, dout=0 and dout_valid=0 on cycle 9. Chained detector gives dout=1 on the 4th bit.
- Back-to-back: 8'hA5 then 8'h3C, load_valid held high -> 16 contiguous valid bits 1010010100111100, second accept on the 8th bit cycle, two frame_done pulses 8 cycles apart.
- LSB-first (MSB_FIRST=0), load_data=8'h0D -> dout = 1,0,1,1,0,0,0,0.
- Busy hold-off: present 8'hFF at cycle 0 and keep load_valid=1 with load_data=8'h00 from cycle 2 -> 8'h00 accepted only at the 8th bit edge. First word emits eight 1s, then eight 0s follow.
- Reset mid-word: assert rst=0 after 3 bits of 8'hF0 -> dout=0 and busy=0 immediately, no frame_done. After release, the new word 8'h81 serializes cleanly as 10000001.
